// File: rtl/conv2d_pkg.sv
// conv2d_pkg -- shared definitions for the streaming 2-D convolution block.
//   state_t  : job-control FSM encoding
//   acc_w_f  : full-precision accumulator width for a DW-bit, KxK convolution
//   *_DEF    : default pixel/coefficient width, kernel size and max image width
package conv2d_pkg;

  localparam int DW_DEF    = 16;
  localparam int K_DEF     = 3;
  localparam int MAX_W_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STREAM,
    ST_FLUSH,
    ST_FIN
  } state_t;

  // Each product needs 2*DW bits; summing K*K of them adds clog2(K*K) bits.
  function automatic int acc_w_f(input int dw, input int k);
    return 2 * dw + $clog2(k * k);
  endfunction

endpackage

// File: rtl/conv2d_line_buffer.sv
// conv2d_line_buffer -- K-1 row FIFOs (depth MAX_W, runtime length img_w).
//   clk, rst : clock, asynchronous active-high reset (pointer only)
//   clear    : restart the column pointer at the beginning of a job
//   shift    : a pixel is accepted this cycle
//   img_w    : active row length
//   pix_in   : accepted pixel
//   col_out  : K-tall pixel column ending at pix_in; col_out[0] is the oldest row
module conv2d_line_buffer
  import conv2d_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int K     = K_DEF,
  parameter int MAX_W = MAX_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 shift,
  input  logic [7:0]           img_w,
  input  logic signed [DW-1:0] pix_in,
  output logic signed [DW-1:0] col_out [K]
);

  localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  logic [AW-1:0]        ptr;
  logic [AW-1:0]        last_ptr;
  logic signed [DW-1:0] mem [K-1][MAX_W];

  assign last_ptr = AW'(img_w - 8'd1);

  // All rows share one pointer: a single circular address per column slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (shift) begin
      ptr <= (ptr == last_ptr) ? '0 : ptr + 1'b1;
    end
  end

  // Each slot ages by one row: mem[K-2] holds the previous row, mem[0] the oldest.
  always_ff @(posedge clk) begin
    if (shift) begin
      for (int j = 0; j < K - 2; j++) begin
        mem[j][ptr] <= mem[j + 1][ptr];
      end
      mem[K-2][ptr] <= pix_in;
    end
  end

  always_comb begin
    for (int m = 0; m < K - 1; m++) begin
      col_out[m] = mem[m][ptr];
    end
    col_out[K-1] = pix_in;
  end

endmodule

// File: rtl/conv2d_stream.sv
// conv2d_stream -- streaming KxK signed 2-D convolution, one result per cycle.
//   clk, rst                       : clock, asynchronous active-high reset
//   start, img_w, img_h            : job launch and image size (sampled on start)
//   coef_valid, coef_data          : row-major kernel load, K*K words
//   in_valid, in_ready, in_data    : row-major pixel stream
//   out_valid, out_ready, out_data : full-precision result stream
//   out_last                       : marks the final result of a job
//   busy, done, err                : status (err is sticky until the next start)
module conv2d_stream
  import conv2d_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int K     = K_DEF,
  parameter int MAX_W = MAX_W_DEF,
  parameter int ACC_W = acc_w_f(DW, K)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [7:0]              img_w,
  input  logic [7:0]              img_h,
  input  logic                    coef_valid,
  input  logic signed [DW-1:0]    coef_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [DW-1:0]    in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int NC = K * K;
  localparam int CW = (NC > 1) ? $clog2(NC) : 1;
  localparam int PW = 2 * DW;
  localparam logic [CW-1:0] COEF_LAST = CW'(NC - 1);
  localparam logic [7:0]    KM1       = 8'(K - 1);

  state_t state, state_nxt;

  logic [7:0]           img_w_q, img_h_q;
  logic [7:0]           col_cnt, row_cnt;
  logic [CW-1:0]        coef_cnt;
  logic signed [DW-1:0] coef [NC];
  logic signed [DW-1:0] col [K];
  logic signed [DW-1:0] win_p0 [K][K];
  logic signed [DW-1:0] win_nxt [K][K];
  logic signed [ACC_W-1:0] acc;
  logic bad_dims, pix_acc, last_pix, win_done;

  function automatic logic signed [PW-1:0] mul_f(input logic signed [DW-1:0] a,
                                                 input logic signed [DW-1:0] b);
    return PW'(a) * PW'(b);
  endfunction

  assign bad_dims = (int'(img_w) < K) || (int'(img_w) > MAX_W) || (int'(img_h) < K);
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_FIN);
  assign in_ready = (state == ST_STREAM) && (!out_valid || out_ready);
  assign pix_acc  = in_valid && in_ready;
  assign last_pix = (row_cnt == img_h_q - 8'd1) && (col_cnt == img_w_q - 8'd1);
  assign win_done = pix_acc && (row_cnt >= KM1) && (col_cnt >= KM1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = bad_dims ? ST_FIN : ST_LOAD;
      ST_LOAD:   if (coef_valid && (coef_cnt == COEF_LAST)) state_nxt = ST_STREAM;
      ST_STREAM: if (pix_acc && last_pix) state_nxt = ST_FLUSH;
      ST_FLUSH:  if (!out_valid || out_ready) state_nxt = ST_FIN;
      ST_FIN:    state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      img_w_q  <= '0;
      img_h_q  <= '0;
      col_cnt  <= '0;
      row_cnt  <= '0;
      coef_cnt <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            img_w_q  <= img_w;
            img_h_q  <= img_h;
            col_cnt  <= '0;
            row_cnt  <= '0;
            coef_cnt <= '0;
            err      <= bad_dims;
          end
        end
        ST_LOAD: if (coef_valid) coef_cnt <= coef_cnt + 1'b1;
        ST_STREAM: begin
          if (pix_acc) begin
            if (col_cnt == img_w_q - 8'd1) begin
              col_cnt <= '0;
              row_cnt <= row_cnt + 8'd1;
            end else begin
              col_cnt <= col_cnt + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((state == ST_LOAD) && coef_valid) coef[coef_cnt] <= coef_data;
  end

  conv2d_line_buffer #(
    .DW    (DW),
    .K     (K),
    .MAX_W (MAX_W)
  ) u_line_buffer (
    .clk     (clk),
    .rst     (rst),
    .clear   ((state == ST_IDLE) && start),
    .shift   (pix_acc),
    .img_w   (img_w_q),
    .pix_in  (in_data),
    .col_out (col)
  );

  // Window slides left by one column; the new column enters on the right.
  always_comb begin
    for (int m = 0; m < K; m++) begin
      for (int n = 0; n < K - 1; n++) begin
        win_nxt[m][n] = win_p0[m][n + 1];
      end
      win_nxt[m][K-1] = col[m];
    end
  end

  always_comb begin
    acc = '0;
    for (int m = 0; m < K; m++) begin
      for (int n = 0; n < K; n++) begin
        acc = acc + ACC_W'(mul_f(coef[m * K + n], win_nxt[m][n]));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pix_acc) win_p0 <= win_nxt;
  end

  // ---- p0 -> output: window sum registered; reload wins over drain for zero bubbles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (win_done) begin
      out_valid <= 1'b1;
      out_last  <= last_pix;
      out_data  <= acc;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: doc/conv2d_stream.md
CONV2D_STREAM -- requirements
Module: conv2d_stream

Interface
REQ-001 Parameter DW, default 16, signed two's-complement pixel and coefficient width.
REQ-002 Parameter K, default 3, square kernel size (2..7).
REQ-003 Parameter MAX_W, default 64, maximum image width; sizes the line buffers.
REQ-004 Parameter ACC_W, default 2*DW+$clog2(K*K), output width, full precision, never overflows.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  one-cycle pulse; begins a job; honoured only in IDLE.
REQ-008 img_w, img_h  in  8 each  image size; sampled on start.
REQ-009 coef_valid  in  1 / coef_data  in  DW  kernel load, row-major, K*K words.
REQ-010 in_valid  in  1 / in_ready  out  1 / in_data  in  DW  pixel stream, row-major.
REQ-011 out_valid  out  1 / out_ready  in  1 / out_data  out  ACC_W  result stream.
REQ-012 out_last  out  1  high with the final result of a job.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 err  out  1  sticky until the next start; flags illegal dimensions.

Function
REQ-016 States: IDLE, LOAD, STREAM, FLUSH, FIN.
- IDLE -> LOAD on start.
- LOAD -> STREAM after K*K coef_valid beats.
- STREAM -> FLUSH after img_w*img_h accepted pixels.
- FLUSH -> FIN when the output register is empty.
- FIN -> IDLE unconditionally.
REQ-017 Dimension check on start: if img_w<K, img_w>MAX_W or img_h<K, then err=1, go directly to FIN, load no coefficients and produce no outputs.
REQ-018 A transfer occurs on valid&&ready; no transfer happens on any other cycle.
REQ-019 in_ready = (state==STREAM) && (!out_valid || out_ready).
REQ-020 Each accepted pixel at (r,c) with r>=K-1 and c>=K-1 completes a window.
- Next cycle: out_valid=1.
- out_data = sum over m,n in 0..K-1 of coef[m][n]*pix[r-K+1+m][c-K+1+n], signed.
- Latency is exactly 1 cycle.
REQ-021 Pixels that do not complete a window update the line buffers and produce no output.
REQ-022 Result count is (img_w-K+1)*(img_h-K+1); out_last is asserted on the last one only.
REQ-023 While out_valid=1 and out_ready=0, out_data and out_last hold stable.
REQ-024 Column counter wraps at img_w-1 and row counter increments; no window spans a row boundary.
REQ-025 Simultaneous output handshake and new window completion: the register reloads with no bubble, sustaining 1 result/cycle.
REQ-026 done pulses in FIN, one cycle after the out_last handshake; for error jobs, one cycle after start.
REQ-027 start while busy is ignored; coef_valid outside LOAD and in_valid outside STREAM are ignored.
REQ-028 Coefficients persist after a job but are reloaded on every job.

Reset
REQ-029 Asserting rst returns the FSM to IDLE, clears all counters, and sets out_valid, out_last, done, err, busy and in_ready to 0 and out_data to 0.
REQ-030 rst mid-job aborts the job with no further output; a subsequent start runs a fresh job. Line-buffer contents need not be cleared.

Structure
REQ-031 Package conv2d_pkg holds the state encoding, the ACC_W derivation function and the default DW/K/MAX_W constants.
REQ-032 Sub-module conv2d_line_buffer holds K-1 row FIFOs of depth MAX_W with runtime length img_w. On each accepted pixel it shifts and presents a K-tall pixel column; conv2d_stream builds the KxK window register from these columns.

Verification
REQ-033 K=3, 4x4 image with pixels 1..16, all-ones kernel -> outputs 54, 63, 90, 99; out_last on 99; done one cycle later.
REQ-034 K=3, 5x5 image with pixels 1..25, kernel center=1 and others 0 -> 9 outputs 7, 8, 9, 12, 13, 14, 17, 18, 19.
REQ-035 Same image as REQ-033; out_ready held low for 10 cycles after the first result -> in_ready low, out_data stable at 54, all four results delivered in order.
REQ-036 DW=16; all coefficients -1; all pixels 32767; 3x3 image -> single result -294903 (ACC_W=36), out_last=1.
REQ-037 start with img_w=2 -> err=1, done pulse, zero out_valid beats, in_ready never high.
REQ-038 rst asserted after 6 pixels of a 4x4 job -> all outputs 0 and busy=0 next cycle; a rerun of the REQ-033 job yields 54, 63, 90, 99.
